// File: rtl/iob_fir_decim_if.sv
// Decimator control, input sample and output stream bundle.
// slave is the decimator side, master is the producer/consumer side.
interface iob_fir_decim_if #(
  parameter int DATA_W  = 8,
  parameter int DECIM_W = 4,
  parameter int FIFO_AW = 2
);
  logic                     en;
  logic [DECIM_W-1:0]       decim;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [FIFO_AW:0]         level;
  logic                     overflow;
  logic                     ovf_clr;

  modport slave (
    input  en,
    input  decim,
    input  data_in,
    input  out_ready,
    input  ovf_clr,
    output data_out,
    output out_valid,
    output level,
    output overflow
  );

  modport master (
    output en,
    output decim,
    output data_in,
    output out_ready,
    output ovf_clr,
    input  data_out,
    input  out_valid,
    input  level,
    input  overflow
  );
endinterface

// File: rtl/iob_fir_decim.sv
// FIR output decimator: keeps one sample in decim+1 and queues it
// in a small first-word fall-through FIFO with a sticky overflow flag.
module iob_fir_decim #(
  parameter int DATA_W  = 8,
  parameter int DECIM_W = 4,
  parameter int FIFO_AW = 2
) (
  input logic          clk,
  input logic          rst,
  iob_fir_decim_if.slave io
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] LV_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LV_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] P_ONE = FIFO_AW'(1);
  localparam logic [DECIM_W-1:0] C_ONE = DECIM_W'(1);

  logic [DECIM_W-1:0] cnt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   level_q;
  logic               ovf_q;

  logic capture;
  logic empty;
  logic full;
  logic pop;
  logic wr;
  logic drop;

  assign capture = io.en && (cnt == '0);
  assign empty   = (level_q == '0);
  assign full    = (level_q == LV_FULL);
  assign pop     = !empty && io.out_ready;
  // A full FIFO still accepts a capture when the head leaves this cycle
  assign wr      = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!io.en || cnt >= io.decim) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= io.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      level_q <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + P_ONE;
      end
      if (pop) begin
        rptr <= rptr + P_ONE;
      end
      unique case (1'b1)
        wr && !pop: level_q <= level_q + LV_ONE;
        pop && !wr: level_q <= level_q - LV_ONE;
        default:    level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (io.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign io.data_out  = empty ? '0 : mem[rptr];
  assign io.out_valid = !empty;
  assign io.level     = level_q;
  assign io.overflow  = ovf_q;
endmodule
